// File: rtl/uart_tx_fifo_arbiter_if.sv
// Requester-side and FIFO-write-side signals of the UART TX FIFO arbiter.
// The slave modport is the arbiter. The master modport is the requesters and the FIFO together.
interface uart_tx_fifo_arbiter_if #(
  parameter int NREQ  = 2,
  parameter int DBITS = 8
);
  logic [NREQ-1:0]       REQ_VALID_I;
  logic [NREQ*DBITS-1:0] REQ_DATA_I;
  logic [NREQ-1:0]       REQ_LAST_I;
  logic [NREQ-1:0]       REQ_READY_O;
  logic                  FIFO_FULL_I;
  logic                  FIFO_WE_O;
  logic [DBITS-1:0]      FIFO_W_DATA_O;
  logic [NREQ-1:0]       GRANT_O;
  logic                  BUSY_O;
  logic                  OVERRUN_O;

  modport master (
    output REQ_VALID_I, REQ_DATA_I, REQ_LAST_I, FIFO_FULL_I,
    input  REQ_READY_O, FIFO_WE_O, FIFO_W_DATA_O, GRANT_O, BUSY_O, OVERRUN_O
  );

  modport slave (
    input  REQ_VALID_I, REQ_DATA_I, REQ_LAST_I, FIFO_FULL_I,
    output REQ_READY_O, FIFO_WE_O, FIFO_W_DATA_O, GRANT_O, BUSY_O, OVERRUN_O
  );
endinterface

// File: rtl/uart_tx_fifo_arbiter.sv
// Packet-atomic round-robin arbiter sharing one UART TX FIFO write port between NREQ byte streams.
// A requester is forced to release the port after MAX_LEN bytes without a LAST flag.
module uart_tx_fifo_arbiter #(
  parameter int NREQ    = 2,
  parameter int DBITS   = 8,
  parameter int MAX_LEN = 64,
  parameter int LBITS   = $clog2(MAX_LEN + 1)
) (
  input  logic                   CLK_I,
  input  logic                   RST_NI,
  uart_tx_fifo_arbiter_if.slave  bus
);
  localparam int OBITS = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q;
  logic [OBITS-1:0] owner_q;
  logic [OBITS-1:0] last_q;
  logic [NREQ-1:0]  grant_q;
  logic [LBITS-1:0] count_q;
  logic [LBITS-1:0] count_d;
  logic             overrun_q;

  logic [DBITS-1:0] req_data [NREQ];
  logic [NREQ-1:0]  ready;
  logic [DBITS-1:0] owner_data;
  logic             owner_valid;
  logic             owner_last;
  logic             locked;
  logic             xfer;
  logic             pick_found;
  logic [OBITS-1:0] pick_idx;

  assign locked = (state_q == LOCKED);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
    assign req_data[gi] = bus.REQ_DATA_I[gi*DBITS +: DBITS];
    assign ready[gi]    = locked && (owner_q == OBITS'(gi)) && !bus.FIFO_FULL_I;
  end

  assign owner_data  = req_data[owner_q];
  assign owner_valid = bus.REQ_VALID_I[owner_q];
  assign owner_last  = bus.REQ_LAST_I[owner_q];
  assign xfer        = locked && owner_valid && !bus.FIFO_FULL_I;
  assign count_d     = count_q + LBITS'(1);

  // Scan starts just past the previous owner, so the last winner ranks lowest.
  always_comb begin : arb_comb
    int idx_v;
    idx_v      = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx_v = (int'(last_q) + k) % NREQ;
      if (!pick_found && bus.REQ_VALID_I[idx_v]) begin
        pick_found = 1'b1;
        pick_idx   = OBITS'(idx_v);
      end
    end
  end

  assign bus.REQ_READY_O   = ready;
  assign bus.FIFO_WE_O     = xfer;
  assign bus.FIFO_W_DATA_O = xfer ? owner_data : '0;
  assign bus.GRANT_O       = grant_q;
  assign bus.BUSY_O        = locked;
  assign bus.OVERRUN_O     = overrun_q;

  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= OBITS'(NREQ - 1);
      grant_q   <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            owner_q <= pick_idx;
            grant_q <= NREQ'(1) << pick_idx;
            count_q <= '0;
            state_q <= LOCKED;
          end
        end
        LOCKED: begin
          if (xfer) begin
            count_q <= count_d;
            // A LAST on the MAX_LEN-th byte is an ordinary end of packet.
            if (owner_last) begin
              state_q <= IDLE;
              last_q  <= owner_q;
              grant_q <= '0;
            end else if (count_d == LBITS'(MAX_LEN)) begin
              state_q   <= IDLE;
              last_q    <= owner_q;
              grant_q   <= '0;
              overrun_q <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_arbiter.sv
// Self-checking bench: hand-computed vector table, hand-written corner sequences, then random
// traffic against a packet-level reference model of the arbiter.
module tb_uart_tx_fifo_arbiter;
  localparam int NREQ    = 2;
  localparam int DBITS   = 8;
  localparam int MAX_LEN = 4;

  logic CLK_I;
  logic RST_NI;

  uart_tx_fifo_arbiter_if #(.NREQ(NREQ), .DBITS(DBITS)) bus ();

  uart_tx_fifo_arbiter #(.NREQ(NREQ), .DBITS(DBITS), .MAX_LEN(MAX_LEN)) dut (
    .CLK_I  (CLK_I),
    .RST_NI (RST_NI),
    .bus    (bus)
  );

  initial CLK_I = 1'b0;
  always #5 CLK_I = ~CLK_I;

  typedef struct {
    logic [1:0] valid;
    logic [1:0] last;
    logic [7:0] d0;
    logic [7:0] d1;
    logic       full;
    logic [1:0] grant;
    logic [1:0] ready;
    logic       we;
    logic [7:0] wdata;
    logic       busy;
    logic       ovr;
  } vec_t;

  int n_vec = 0;
  int n_err = 0;

  function automatic vec_t mk(input logic [1:0] v, input logic [1:0] l, input logic [7:0] d0,
                              input logic [7:0] d1, input logic f, input logic [1:0] g,
                              input logic [1:0] r, input logic w, input logic [7:0] wd,
                              input logic b, input logic o);
    vec_t x;
    x.valid = v; x.last = l; x.d0 = d0; x.d1 = d1; x.full = f;
    x.grant = g; x.ready = r; x.we = w; x.wdata = wd; x.busy = b; x.ovr = o;
    return x;
  endfunction

  task automatic drive(input logic [1:0] v, input logic [1:0] l, input logic [7:0] d0,
                       input logic [7:0] d1, input logic f);
    bus.REQ_VALID_I = v;
    bus.REQ_LAST_I  = l;
    bus.REQ_DATA_I  = {d1, d0};
    bus.FIFO_FULL_I = f;
  endtask

  task automatic check(input string name, input logic [1:0] g, input logic [1:0] r,
                       input logic w, input logic [7:0] wd, input logic b, input logic o);
    n_vec++;
    if (bus.GRANT_O !== g || bus.REQ_READY_O !== r || bus.FIFO_WE_O !== w ||
        bus.FIFO_W_DATA_O !== wd || bus.BUSY_O !== b || bus.OVERRUN_O !== o) begin
      n_err++;
      $display("FAIL %s: got grant=%b ready=%b we=%b wdata=%h busy=%b ovr=%b, expected grant=%b ready=%b we=%b wdata=%h busy=%b ovr=%b",
               name, bus.GRANT_O, bus.REQ_READY_O, bus.FIFO_WE_O, bus.FIFO_W_DATA_O,
               bus.BUSY_O, bus.OVERRUN_O, g, r, w, wd, b, o);
    end
  endtask

  // One cycle: drive at the falling edge, check 1 ns later, well clear of the rising edge.
  task automatic step(input string name, input logic [1:0] v, input logic [1:0] l,
                      input logic [7:0] d0, input logic [7:0] d1, input logic f,
                      input logic [1:0] g, input logic [1:0] r, input logic w,
                      input logic [7:0] wd, input logic b, input logic o);
    @(negedge CLK_I);
    drive(v, l, d0, d1, f);
    #1;
    check(name, g, r, w, wd, b, o);
  endtask

  vec_t tbl[19];

  // Reference model: owner is -1 when nobody holds the port.
  int         m_owner;
  int         m_last;
  int         m_cnt;
  bit         m_ovr;
  logic [1:0] e_grant, e_ready;
  logic       e_we;
  logic [7:0] e_wdata;
  logic [7:0] rd [2];
  logic [1:0] rv, rl;
  logic       rf;

  initial begin
    RST_NI = 1'b0;
    drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);

    //             valid  last   d0     d1     full   grant  ready  we  wdata  busy ovr
    tbl[0]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 0, 8'h00, 0, 0);
    tbl[1]  = mk(2'b01, 2'b00, 8'h11, 8'h00, 1'b0, 2'b00, 2'b00, 0, 8'h00, 0, 0);
    tbl[2]  = mk(2'b01, 2'b00, 8'h11, 8'h00, 1'b0, 2'b01, 2'b01, 1, 8'h11, 1, 0);
    tbl[3]  = mk(2'b01, 2'b00, 8'h22, 8'h00, 1'b0, 2'b01, 2'b01, 1, 8'h22, 1, 0);
    tbl[4]  = mk(2'b01, 2'b01, 8'h33, 8'h00, 1'b0, 2'b01, 2'b01, 1, 8'h33, 1, 0);
    tbl[5]  = mk(2'b00, 2'b00, 8'h00, 8'h00, 1'b0, 2'b00, 2'b00, 0, 8'h00, 0, 0);
    tbl[6]  = mk(2'b11, 2'b00, 8'hA0, 8'hB0, 1'b0, 2'b00, 2'b00, 0, 8'h00, 0, 0);
    tbl[7]  = mk(2'b11, 2'b00, 8'hA0, 8'hB0, 1'b0, 2'b10, 2'b10, 1, 8'hB0, 1, 0);
    tbl[8]  = mk(2'b11, 2'b10, 8'hA0, 8'hB1, 1'b0, 2'b10, 2'b10, 1, 8'hB1, 1, 0);
    tbl[9]  = mk(2'b11, 2'b00, 8'hA0, 8'hB0, 1'b0, 2'b00, 2'b00, 0, 8'h00, 0, 0);
    tbl[10] = mk(2'b11, 2'b10, 8'hA0, 8'hB0, 1'b0, 2'b01, 2'b01, 1, 8'hA0, 1, 0);
    tbl[11] = mk(2'b11, 2'b01, 8'hA1, 8'hB0, 1'b0, 2'b01, 2'b01, 1, 8'hA1, 1, 0);
    tbl[12] = mk(2'b11, 2'b00, 8'hA0, 8'hB0, 1'b0, 2'b00, 2'b00, 0, 8'h00, 0, 0);
    tbl[13] = mk(2'b10, 2'b00, 8'h00, 8'h5A, 1'b0, 2'b10, 2'b10, 1, 8'h5A, 1, 0);
    tbl[14] = mk(2'b10, 2'b10, 8'h00, 8'hA5, 1'b1, 2'b10, 2'b00, 0, 8'h00, 1, 0);
    tbl[15] = mk(2'b10, 2'b10, 8'h00, 8'hA5, 1'b1, 2'b10, 2'b00, 0, 8'h00, 1, 0);
    tbl[16] = mk(2'b10, 2'b10, 8'h00, 8'hA5, 1'b1, 2'b10, 2'b00, 0, 8'h00, 1, 0);
    tbl[17] = mk(2'b10, 2'b10, 8'h00, 8'hA5, 1'b0, 2'b10, 2'b10, 1, 8'hA5, 1, 0);
    tbl[18] = mk(2'b00, 2'b00, 8'h00, 8'h00, 1'b1, 2'b00, 2'b00, 0, 8'h00, 0, 0);

    repeat (2) @(negedge CLK_I);
    #1;
    check("reset_state", 2'b00, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0);
    @(negedge CLK_I);
    RST_NI = 1'b1;

    for (int i = 0; i < 19; i++)
      step($sformatf("tbl%0d", i), tbl[i].valid, tbl[i].last, tbl[i].d0, tbl[i].d1, tbl[i].full,
           tbl[i].grant, tbl[i].ready, tbl[i].we, tbl[i].wdata, tbl[i].busy, tbl[i].ovr);

    // Overrun: req0 never sends LAST, req1 waits.
    step("ovr_arb", 2'b11, 2'b00, 8'hC0, 8'hD0, 0, 2'b00, 2'b00, 0, 8'h00, 0, 0);
    for (int i = 0; i < MAX_LEN; i++)
      step($sformatf("ovr_byte%0d", i), 2'b11, 2'b00, 8'(8'hC0 + i), 8'hD0, 0,
           2'b01, 2'b01, 1, 8'(8'hC0 + i), 1, 0);
    step("ovr_pulse", 2'b11, 2'b00, 8'hC4, 8'hD0, 0, 2'b00, 2'b00, 0, 8'h00, 0, 1);
    step("ovr_req1", 2'b11, 2'b10, 8'hC5, 8'hD0, 0, 2'b10, 2'b10, 1, 8'hD0, 1, 0);
    step("ovr_done", 2'b00, 2'b00, 8'h00, 8'h00, 0, 2'b00, 2'b00, 0, 8'h00, 0, 0);

    // Reset in the middle of a req1 packet.
    step("rst_arb", 2'b10, 2'b00, 8'h00, 8'hE0, 0, 2'b00, 2'b00, 0, 8'h00, 0, 0);
    step("rst_b0", 2'b10, 2'b00, 8'h00, 8'hE0, 0, 2'b10, 2'b10, 1, 8'hE0, 1, 0);
    step("rst_b1", 2'b10, 2'b00, 8'h00, 8'hE1, 0, 2'b10, 2'b10, 1, 8'hE1, 1, 0);
    @(negedge CLK_I);
    drive(2'b10, 2'b00, 8'h00, 8'hE2, 1'b0);
    RST_NI = 1'b0;
    #1;
    check("rst_async", 2'b00, 2'b00, 0, 8'h00, 0, 0);
    for (int i = 0; i < 2; i++)
      step($sformatf("rst_hold%0d", i), 2'b11, 2'b00, 8'h77, 8'hE2, 0,
           2'b00, 2'b00, 0, 8'h00, 0, 0);
    @(negedge CLK_I);
    RST_NI = 1'b1;
    drive(2'b11, 2'b00, 8'h77, 8'hE2, 1'b0);
    #1;
    check("rst_rel", 2'b00, 2'b00, 0, 8'h00, 0, 0);
    step("rst_req0", 2'b11, 2'b01, 8'h77, 8'hE2, 0, 2'b01, 2'b01, 1, 8'h77, 1, 0);
    step("rst_arb1", 2'b10, 2'b10, 8'h00, 8'hE3, 0, 2'b00, 2'b00, 0, 8'h00, 0, 0);
    step("rst_req1", 2'b10, 2'b10, 8'h00, 8'hE3, 0, 2'b10, 2'b10, 1, 8'hE3, 1, 0);

    // Stalled owner: req0 drops VALID mid-packet while req1 waits.
    step("stl_arb", 2'b11, 2'b00, 8'hF0, 8'hB9, 0, 2'b00, 2'b00, 0, 8'h00, 0, 0);
    step("stl_b0", 2'b11, 2'b00, 8'hF0, 8'hB9, 0, 2'b01, 2'b01, 1, 8'hF0, 1, 0);
    for (int i = 0; i < 10; i++)
      step($sformatf("stl_hold%0d", i), 2'b10, 2'b10, 8'h00, 8'hB9, 0,
           2'b01, 2'b01, 0, 8'h00, 1, 0);
    step("stl_last", 2'b11, 2'b01, 8'hF1, 8'hB9, 0, 2'b01, 2'b01, 1, 8'hF1, 1, 0);
    step("stl_arb1", 2'b10, 2'b10, 8'h00, 8'hB9, 0, 2'b00, 2'b00, 0, 8'h00, 0, 0);
    step("stl_req1", 2'b10, 2'b10, 8'h00, 8'hB9, 0, 2'b10, 2'b10, 1, 8'hB9, 1, 0);

    // Random traffic against the reference model, from a fresh reset.
    @(negedge CLK_I);
    drive(2'b00, 2'b00, 8'h00, 8'h00, 1'b0);
    RST_NI = 1'b0;
    @(negedge CLK_I);
    RST_NI = 1'b1;
    m_owner = -1; m_last = NREQ - 1; m_cnt = 0; m_ovr = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge CLK_I);
      for (int r = 0; r < NREQ; r++) begin
        rv[r] = ($urandom_range(0, 3) != 0);
        rl[r] = ($urandom_range(0, 3) == 0);
        rd[r] = 8'($urandom_range(0, 255));
      end
      rf = ($urandom_range(0, 4) == 0);
      drive(rv, rl, rd[0], rd[1], rf);
      #1;
      e_grant = '0; e_ready = '0; e_we = 1'b0; e_wdata = '0;
      if (m_owner >= 0) begin
        e_grant[m_owner] = 1'b1;
        e_ready[m_owner] = !rf;
        e_we             = rv[m_owner] && !rf;
        if (e_we) e_wdata = rd[m_owner];
      end
      check($sformatf("rand%0d", i), e_grant, e_ready, e_we, e_wdata, m_owner >= 0, m_ovr);
      m_ovr = 1'b0;
      if (m_owner < 0) begin
        for (int k = 1; k <= NREQ; k++)
          if (m_owner < 0 && rv[(m_last + k) % NREQ]) begin
            m_owner = (m_last + k) % NREQ;
            m_cnt   = 0;
          end
      end else if (e_we) begin
        m_cnt++;
        if (rl[m_owner]) begin
          m_last = m_owner; m_owner = -1;
        end else if (m_cnt == MAX_LEN) begin
          m_last = m_owner; m_owner = -1; m_ovr = 1'b1;
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_arbiter.md
Name: uart_tx_fifo_arbiter

Overview:
- Shares one UART TX byte FIFO write port (8-bit data, FULL flag, write-enable) between NREQ byte-stream requesters, e.g. debug-module response path and status/ack path.
- Grants are round-robin and packet-atomic: once granted, a requester owns the FIFO until it sends a byte flagged LAST, so frames from different requesters never interleave.
- A length guard stops a requester that never sends LAST from locking the FIFO.
- Sits between the requesters and the FIFO write side. The FIFO's own read side is untouched.

Parameters:
- NREQ, 2, number of requesters (2..8)
- DBITS, 8, data width; must equal FIFO data width
- MAX_LEN, 64, maximum bytes per packet before forced release (>=1)
- LBITS, $clog2(MAX_LEN+1), width of the byte counter

Ports:
- CLK_I  in  1  clock, rising edge
- RST_NI  in  1  reset; asynchronous assertion, active-low
- REQ_VALID_I  in  NREQ  per-requester byte valid
- REQ_DATA_I  in  NREQ*DBITS  per-requester byte; requester i uses bits [i*DBITS +: DBITS]
- REQ_LAST_I  in  NREQ  per-requester last-byte-of-packet flag, qualified by VALID
- REQ_READY_O  out  NREQ  per-requester accept; a byte transfers when VALID&READY
- FIFO_FULL_I  in  1  FIFO full flag
- FIFO_WE_O  out  1  FIFO write enable
- FIFO_W_DATA_O  out  DBITS  FIFO write data
- GRANT_O  out  NREQ  one-hot current owner; all-zero in IDLE
- BUSY_O  out  1  high in state LOCKED
- OVERRUN_O  out  1  one-cycle pulse on forced release

Behaviour:
- Reset (RST_NI=0, asynchronous) clears all state:
  - state=IDLE, GRANT_O=0, count=0, OVERRUN_O=0
  - priority pointer last=NREQ-1, so requester 0 has first priority
  - Combinational outputs then evaluate to REQ_READY_O=0, FIFO_WE_O=0, FIFO_W_DATA_O=0.
- Reset mid-packet: the packet is abandoned and no FIFO write occurs while reset is low. After release, arbitration restarts from requester 0.
- FSM states: IDLE, LOCKED.
- IDLE:
  - If any REQ_VALID_I is high, select the first valid index scanning last+1, last+2, ... modulo NREQ.
  - Register that index as owner, set GRANT_O one-hot, count=0, go to LOCKED.
  - Arbitration costs exactly one cycle. No transfer happens in IDLE.
- LOCKED, combinational outputs:
  - xfer = REQ_VALID_I[owner] & ~FIFO_FULL_I
  - REQ_READY_O[owner] = ~FIFO_FULL_I; all other READY bits are 0
  - FIFO_WE_O = xfer
  - FIFO_W_DATA_O = owner's data when xfer, else 0
- LOCKED, on each xfer edge:
  - count <= count+1.
  - If REQ_LAST_I[owner]: go to IDLE, last <= owner, GRANT_O <= 0.
  - Else if count+1 == MAX_LEN: go to IDLE, last <= owner, GRANT_O <= 0, OVERRUN_O pulses high the next cycle.
- Owner drops VALID mid-packet: grant is held, no timeout.
- FIFO_FULL_I high: READY and WE are low. Data stall in the requester, and nothing is dropped or duplicated.
- FIFO_FULL_I is never bypassed. The FIFO itself ignores writes when full, but this block must never assert WE when full.
- LAST and MAX_LEN on the same byte: treated as normal LAST, no OVERRUN_O.
- MAX_LEN=1: every byte is its own packet. OVERRUN_O fires only if LAST is low.
- Back-to-back packets:
  - Minimum gap is one idle cycle between packets (the IDLE arbitration cycle).
  - After a release, the same requester is re-granted only if no other requester is valid.
- Non-owner VALID/LAST/DATA inputs are ignored and must not affect outputs.
- Throughput: one byte per cycle in LOCKED while the FIFO is not full.

Test Plan:
- Single packet, no contention:
  - Stimulus: reset, then req0 sends 0x11,0x22,0x33 (LAST on 0x33).
  - Response: GRANT_O=01 one cycle after VALID; FIFO writes 0x11,0x22,0x33 on consecutive cycles; IDLE after 0x33; BUSY_O low again.
- Contention and round-robin:
  - Stimulus: req0 and req1 both valid from reset with 2-byte packets A0,A1 / B0,B1, repeated.
  - Response: FIFO order A0,A1,B0,B1,A0,A1,B0,B1; never interleaved within a packet.
- Backpressure:
  - Stimulus: req1 packet 0x5A,0xA5 (LAST on 0xA5); FIFO_FULL_I high for 3 cycles after the first write.
  - Response: READY1 and FIFO_WE_O low during those 3 cycles; 0xA5 written once, the cycle FULL drops.
- Overrun guard:
  - Stimulus: MAX_LEN=4; req0 sends 6 bytes with no LAST; req1 is valid.
  - Response: 4 bytes written; OVERRUN_O high for exactly 1 cycle; req1 granted next.
- Reset mid-packet:
  - Stimulus: assert RST_NI low between bytes 2 and 3 of a 5-byte req1 packet.
  - Response: outputs zero immediately (asynchronous), no further writes; after release, req0 has priority.
- Stalled owner:
  - Stimulus: req0 granted, drops VALID for 10 cycles mid-packet; req1 is valid throughout.
  - Response: GRANT_O stays 01; req1 is served only after req0's LAST.
